alt_stats: RTL and testbench
============================

# alt_stats

Parametrised ambient-light / frame-difference statistics engine, the next generation of the ALT block in the DVI-vs-CCD comparison path. It accumulates per-pixel DVI/CCD channel differences over a frame of configurable size and channel widths. At frame end a sequential divider and integer square-root unit compute the per-channel ambient shift, the mean squared frame difference, its variance and a mean-plus-K-sigma threshold. It divides by the actual count of valid pixels, replacing a fixed 640×480 constant, and flags frames dropped while the engine is busy.

## Interface
- H_ACT, 640, active pixels per line; frame-end pixel is syncX = H_ACT-1.
- V_ACT, 480, active lines; frame-end pixel is syncY = V_ACT-1.
- R_W, 5; G_W, 6; B_W, 5: input channel widths, each ≤ DW.
- DW, 6, normalised channel width; inputs are left-shifted by DW-x_W.
- ACC_W, 48, accumulator and divider width; must hold (H_ACT·V_ACT)·FD2max².
- THR_K, 2, sigma multiplier for the threshold.
- clk_25  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- valid_i  in  1  pixel qualifier.
- syncX_i, syncY_i  in  10 each  pixel coordinates.
- DVI_R_i, DVI_G_i, DVI_B_i  in  R_W / G_W / B_W  display pixel.
- CCD_R_i, CCD_G_i, CCD_B_i  in  R_W / G_W / B_W  camera pixel.
- AMB_SHIFT_R_o, AMB_SHIFT_G_o, AMB_SHIFT_B_o  out  8 each  mean |Δ| scaled to 8 bits (mean << (8-DW)).
- mean_fd2_o  out  32  mean of FD² = ΔR²+ΔG²+ΔB².
- var_fd2_o  out  32  mean(FD²²) − mean(FD²)², clamped ≥0, saturated.
- threshold_o  out  32  mean_fd2 + THR_K·isqrt(var), saturated to 0xFFFFFFFF.
- done_o  out  1  one-cycle pulse when all outputs update.
- busy_o  out  1  high while FSM is not IDLE.
- overrun_o  out  1  one-cycle pulse when a frame is dropped.

## Operation
- Stage 0: register inputs when valid_i=1, plus a registered valid flag; channels are normalised to DW bits.
- Stage 1: on registered valid, compute |Δ| per channel, FD² (F = 2·DW+2 bits) and FD²² (2F bits). Add these to accR/G/B, accF2 and accF4, and increment pix_cnt.
- Frame end is the registered valid pixel at (H_ACT-1, V_ACT-1). That pixel is included in the sums.
- On the same cycle: if the FSM is IDLE, copy sums+pixel and pix_cnt into shadow registers; otherwise pulse overrun_o and discard. Live accumulators and pix_cnt clear in both cases.
- FSM states:
  - IDLE: on a shadow load, go to DIV.
  - DIV: five sequential restoring divisions (accR, accG, accB, accF2, accF4) by pix_cnt, one quotient bit per cycle, ACC_W cycles each.
  - VAR: one cycle; var = q4 − q2², or 0 if negative.
  - SQRT: bitwise restoring isqrt of var, F cycles.
  - OUT: one cycle; load all outputs, pulse done_o, go to IDLE.
- If pix_cnt = 0, all quotients are 0, so all outputs are 0 and done_o still pulses.
- Outputs hold their values between done_o pulses.
- Accumulation continues during DIV/SQRT; only shadow registers are consumed.

## Timing
- Reset: all outputs, accumulators, pix_cnt, shadows and the FSM clear to 0 / IDLE immediately and asynchronously. Reset during DIV or SQRT aborts the computation with no done_o.
- Frame-end input sampled at edge n.
- Shadow load occurs at edge n+2.
- done_o is high in cycle n+2+L, with L = 5·ACC_W + F + 2 (defaults: L = 256, done_o at n+258).
- busy_o is high from n+3 through the done_o cycle inclusive.
- overrun_o pulses in the cycle after the dropped frame's end pixel is registered.
- Frame end coinciding with the OUT cycle is dropped; IDLE is only entered the following cycle.

## Test plan
- H_ACT=4, V_ACT=2; all pixels DVI=CCD → AMB 0/0/0, mean 0, var 0, threshold 0, one done_o.
- DVI_R=10, CCD_R=4 (normalised 20 vs 8), G and B equal, all 8 pixels → AMB_R=48, mean_fd2=144, var 0, threshold 144.
- Four pixels with ΔG=0 and four with ΔG=4 → AMB_G=8, mean_fd2=8, var=64, threshold=24.
- Constant ΔR pattern with valid_i low on 3 of 8 pixels → divisor 5; same outputs as the full-frame case.
- Frames back-to-back (8-pixel frames, every 8 cycles) → first frame reports, overrun_o pulses for frames arriving while busy, done_o at n+258.
- reset asserted mid-DIV → outputs 0, busy_o 0, no done_o; the next full frame reports correctly.

Source files
------------

// File: rtl/alt_stats.sv
// alt_stats: accumulates per-pixel DVI/CCD channel differences over a frame. At frame end a
// bit-serial divider and isqrt unit reduce a shadow copy of the sums into the frame statistics.
module alt_stats #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int R_W   = 5,
  parameter int G_W   = 6,
  parameter int B_W   = 5,
  parameter int DW    = 6,
  parameter int ACC_W = 48,
  parameter int THR_K = 2
) (
  input  logic           clk_25,
  input  logic           reset,
  input  logic           valid_i,
  input  logic [9:0]     syncX_i,
  input  logic [9:0]     syncY_i,
  input  logic [R_W-1:0] DVI_R_i,
  input  logic [G_W-1:0] DVI_G_i,
  input  logic [B_W-1:0] DVI_B_i,
  input  logic [R_W-1:0] CCD_R_i,
  input  logic [G_W-1:0] CCD_G_i,
  input  logic [B_W-1:0] CCD_B_i,
  output logic [7:0]     AMB_SHIFT_R_o,
  output logic [7:0]     AMB_SHIFT_G_o,
  output logic [7:0]     AMB_SHIFT_B_o,
  output logic [31:0]    mean_fd2_o,
  output logic [31:0]    var_fd2_o,
  output logic [31:0]    threshold_o,
  output logic           done_o,
  output logic           busy_o,
  output logic           overrun_o
);

  localparam int F     = 2*DW + 2;
  localparam int F2    = 2*F;
  localparam int CNT_W = $clog2(H_ACT*V_ACT + 1);
  localparam int BC_W  = $clog2(ACC_W);
  localparam int SC_W  = $clog2(F);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIV  = 3'd1,
    S_VAR  = 3'd2,
    S_SQRT = 3'd3,
    S_OUT  = 3'd4
  } state_e;

  function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [31:0] sat32(input logic [63:0] v);
    return (|v[63:32]) ? 32'hFFFF_FFFF : v[31:0];
  endfunction

  state_e state_q;

  logic          v0_d, v0_q, e0_d, e0_q, v1_d, v1_q, e1_d, e1_q;
  logic [DW-1:0] dr0_d, dr0_q, dg0_d, dg0_q, db0_d, db0_q;
  logic [DW-1:0] cr0_d, cr0_q, cg0_d, cg0_q, cb0_d, cb0_q;
  logic [DW-1:0] ar1_d, ar1_q, ag1_d, ag1_q, ab1_d, ab1_q;
  logic [F-1:0]  fd2_1_d, fd2_1_q;
  logic [F2-1:0] fd4_1_d, fd4_1_q;

  logic [4:0][ACC_W-1:0] add_s, sum_s, acc_d, acc_q, sh_d, sh_q;
  logic [CNT_W-1:0]      cnt_d, cnt_q, sh_cnt_d, sh_cnt_q;
  logic                  load_s, drop_s;

  // Stage 0 captures normalised channels; stage 1 forms |delta|, FD^2 and FD^4.
  always_comb begin
    v0_d = valid_i;
    e0_d = valid_i && (syncX_i == 10'(H_ACT-1)) && (syncY_i == 10'(V_ACT-1));
    if (valid_i) begin
      dr0_d = DW'(DVI_R_i) << (DW-R_W);
      dg0_d = DW'(DVI_G_i) << (DW-G_W);
      db0_d = DW'(DVI_B_i) << (DW-B_W);
      cr0_d = DW'(CCD_R_i) << (DW-R_W);
      cg0_d = DW'(CCD_G_i) << (DW-G_W);
      cb0_d = DW'(CCD_B_i) << (DW-B_W);
    end else begin
      dr0_d = dr0_q;
      dg0_d = dg0_q;
      db0_d = db0_q;
      cr0_d = cr0_q;
      cg0_d = cg0_q;
      cb0_d = cb0_q;
    end
    v1_d    = v0_q;
    e1_d    = e0_q;
    ar1_d   = abs_diff(dr0_q, cr0_q);
    ag1_d   = abs_diff(dg0_q, cg0_q);
    ab1_d   = abs_diff(db0_q, cb0_q);
    fd2_1_d = F'(ar1_d) * F'(ar1_d) + F'(ag1_d) * F'(ag1_d) + F'(ab1_d) * F'(ab1_d);
    fd4_1_d = F2'(fd2_1_d) * F2'(fd2_1_d);
  end

  // Live accumulation; the frame-end pixel is folded into the shadow copy, never into acc.
  always_comb begin
    add_s[0] = ACC_W'(ar1_q);
    add_s[1] = ACC_W'(ag1_q);
    add_s[2] = ACC_W'(ab1_q);
    add_s[3] = ACC_W'(fd2_1_q);
    add_s[4] = ACC_W'(fd4_1_q);
    for (int i = 0; i < 5; i++) begin
      sum_s[i] = acc_q[i] + add_s[i];
    end
    load_s   = 1'b0;
    drop_s   = 1'b0;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    sh_cnt_d = sh_cnt_q;
    if (v1_q && e1_q) begin
      acc_d = '0;
      cnt_d = '0;
      if (state_q == S_IDLE) begin
        load_s   = 1'b1;
        sh_d     = sum_s;
        sh_cnt_d = cnt_q + CNT_W'(1);
      end else begin
        drop_s = 1'b1;
      end
    end else if (v1_q) begin
      acc_d = sum_s;
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      acc_d = acc_q;
      cnt_d = cnt_q;
    end
  end

  // Pipeline, accumulator and shadow registers.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      v0_q <= 1'b0;  e0_q <= 1'b0;  v1_q <= 1'b0;  e1_q <= 1'b0;
      dr0_q <= '0;   dg0_q <= '0;   db0_q <= '0;
      cr0_q <= '0;   cg0_q <= '0;   cb0_q <= '0;
      ar1_q <= '0;   ag1_q <= '0;   ab1_q <= '0;
      fd2_1_q <= '0; fd4_1_q <= '0;
      acc_q <= '0;   cnt_q <= '0;   sh_q <= '0;   sh_cnt_q <= '0;
    end else begin
      v0_q <= v0_d;  e0_q <= e0_d;  v1_q <= v1_d;  e1_q <= e1_d;
      dr0_q <= dr0_d; dg0_q <= dg0_d; db0_q <= db0_d;
      cr0_q <= cr0_d; cg0_q <= cg0_d; cb0_q <= cb0_d;
      ar1_q <= ar1_d; ag1_q <= ag1_d; ab1_q <= ab1_d;
      fd2_1_q <= fd2_1_d; fd4_1_q <= fd4_1_d;
      acc_q <= acc_d; cnt_q <= cnt_d; sh_q <= sh_d; sh_cnt_q <= sh_cnt_d;
    end
  end

  logic [2:0]            div_idx_q;
  logic [BC_W-1:0]       bit_q;
  logic [ACC_W-1:0]      rem_q, dq_q;
  logic [4:0][ACC_W-1:0] q_q;
  logic [F2-1:0]         var_q, sq_src_q;
  logic [F+1:0]          sq_rem_q;
  logic [F-1:0]          root_q;
  logic [SC_W-1:0]       sq_cnt_q;
  logic [7:0]            amb_r_q, amb_g_q, amb_b_q;
  logic [31:0]           mean_q, var_out_q, thr_q;
  logic                  done_q, busy_q, overrun_q;

  logic [ACC_W:0]   div_trial_s, div_den_s;
  logic             div_ge_s, sq_ge_s;
  logic [ACC_W-1:0] div_rem_s, div_quo_s, div_res_s;
  logic [F+3:0]     sq_trial_s, sq_test_s;
  logic [F+1:0]     sq_rem_nx_s;
  logic [F-1:0]     root_nx_s;
  logic [F2-1:0]    mean_f2_s, mean_f4_s, f2sq_s, var_s;
  logic [63:0]      thr_s;

  // One restoring-division step, one isqrt step, and the variance/threshold arithmetic.
  always_comb begin
    div_den_s   = (ACC_W+1)'(sh_cnt_q);
    div_trial_s = {rem_q, dq_q[ACC_W-1]};
    div_ge_s    = (div_trial_s >= div_den_s);
    div_rem_s   = div_ge_s ? ACC_W'(div_trial_s - div_den_s) : ACC_W'(div_trial_s);
    div_quo_s   = {dq_q[ACC_W-2:0], div_ge_s};
    div_res_s   = (sh_cnt_q == CNT_W'(0)) ? ACC_W'(0) : div_quo_s;

    sq_trial_s  = {sq_rem_q, sq_src_q[F2-1 -: 2]};
    sq_test_s   = (F+4)'({root_q, 2'b01});
    sq_ge_s     = (sq_trial_s >= sq_test_s);
    sq_rem_nx_s = sq_ge_s ? (F+2)'(sq_trial_s - sq_test_s) : (F+2)'(sq_trial_s);
    root_nx_s   = {root_q[F-2:0], sq_ge_s};

    mean_f2_s   = F2'(q_q[3]);
    mean_f4_s   = F2'(q_q[4]);
    f2sq_s      = mean_f2_s * mean_f2_s;
    var_s       = (mean_f4_s >= f2sq_s) ? (mean_f4_s - f2sq_s) : F2'(0);
    thr_s       = 64'(mean_f2_s) + 64'(THR_K) * 64'(root_q);
  end

  // Sequencer: DIV x5 -> VAR -> SQRT -> OUT, working only from the shadow registers.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      div_idx_q <= '0;  bit_q <= '0;  rem_q <= '0;  dq_q <= '0;  q_q <= '0;
      var_q     <= '0;  sq_src_q <= '0;  sq_rem_q <= '0;  root_q <= '0;  sq_cnt_q <= '0;
      amb_r_q   <= '0;  amb_g_q <= '0;  amb_b_q <= '0;
      mean_q    <= '0;  var_out_q <= '0;  thr_q <= '0;
      done_q    <= 1'b0;  busy_q <= 1'b0;  overrun_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      busy_q    <= (state_q != S_IDLE);
      overrun_q <= drop_s;
      case (state_q)
        S_IDLE: begin
          if (load_s) begin
            state_q   <= S_DIV;
            div_idx_q <= 3'd0;
            bit_q     <= '0;
            rem_q     <= '0;
            dq_q      <= sh_d[0];
          end else begin
            state_q   <= S_IDLE;
          end
        end
        S_DIV: begin
          rem_q <= div_rem_s;
          dq_q  <= div_quo_s;
          if (bit_q == BC_W'(ACC_W-1)) begin
            q_q[div_idx_q] <= div_res_s;
            bit_q <= '0;
            rem_q <= '0;
            if (div_idx_q == 3'd4) begin
              state_q <= S_VAR;
            end else begin
              div_idx_q <= div_idx_q + 3'd1;
              dq_q      <= sh_q[div_idx_q + 3'd1];
            end
          end else begin
            bit_q <= bit_q + BC_W'(1);
          end
        end
        S_VAR: begin
          var_q    <= var_s;
          sq_src_q <= var_s;
          sq_rem_q <= '0;
          root_q   <= '0;
          sq_cnt_q <= '0;
          state_q  <= S_SQRT;
        end
        S_SQRT: begin
          sq_rem_q <= sq_rem_nx_s;
          root_q   <= root_nx_s;
          sq_src_q <= sq_src_q << 2;
          if (sq_cnt_q == SC_W'(F-1)) begin
            state_q <= S_OUT;
          end else begin
            sq_cnt_q <= sq_cnt_q + SC_W'(1);
          end
        end
        S_OUT: begin
          amb_r_q   <= 8'(q_q[0] << (8-DW));
          amb_g_q   <= 8'(q_q[1] << (8-DW));
          amb_b_q   <= 8'(q_q[2] << (8-DW));
          mean_q    <= sat32(64'(mean_f2_s));
          var_out_q <= sat32(64'(var_q));
          thr_q     <= sat32(thr_s);
          done_q    <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign AMB_SHIFT_R_o = amb_r_q;
  assign AMB_SHIFT_G_o = amb_g_q;
  assign AMB_SHIFT_B_o = amb_b_q;
  assign mean_fd2_o    = mean_q;
  assign var_fd2_o     = var_out_q;
  assign threshold_o   = thr_q;
  assign done_o        = done_q;
  assign busy_o        = busy_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_alt_stats.sv
// Randomised bench for alt_stats on a 4x2 frame, checked against an arithmetic frame model.
module tb_alt_stats;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int NPIX  = H*V;
  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int DW    = 6;
  localparam int ACC_W = 48;
  localparam int THR_K = 2;
  localparam int LAT   = 5*ACC_W + (2*DW+2) + 2;

  logic clk_25 = 1'b0;
  logic reset = 1'b1;
  logic valid_i = 1'b0;
  logic [9:0] syncX_i = '0, syncY_i = '0;
  logic [R_W-1:0] DVI_R_i = '0, CCD_R_i = '0;
  logic [G_W-1:0] DVI_G_i = '0, CCD_G_i = '0;
  logic [B_W-1:0] DVI_B_i = '0, CCD_B_i = '0;
  logic [7:0] AMB_SHIFT_R_o, AMB_SHIFT_G_o, AMB_SHIFT_B_o;
  logic [31:0] mean_fd2_o, var_fd2_o, threshold_o;
  logic done_o, busy_o, overrun_o;

  alt_stats #(.H_ACT(H), .V_ACT(V), .R_W(R_W), .G_W(G_W), .B_W(B_W),
              .DW(DW), .ACC_W(ACC_W), .THR_K(THR_K)) dut (
    .clk_25(clk_25), .reset(reset), .valid_i(valid_i),
    .syncX_i(syncX_i), .syncY_i(syncY_i),
    .DVI_R_i(DVI_R_i), .DVI_G_i(DVI_G_i), .DVI_B_i(DVI_B_i),
    .CCD_R_i(CCD_R_i), .CCD_G_i(CCD_G_i), .CCD_B_i(CCD_B_i),
    .AMB_SHIFT_R_o(AMB_SHIFT_R_o), .AMB_SHIFT_G_o(AMB_SHIFT_G_o), .AMB_SHIFT_B_o(AMB_SHIFT_B_o),
    .mean_fd2_o(mean_fd2_o), .var_fd2_o(var_fd2_o), .threshold_o(threshold_o),
    .done_o(done_o), .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always #20 clk_25 = ~clk_25;

  typedef struct {
    longint cyc;
    longint amb_r, amb_g, amb_b, mean, vr, thr;
  } res_t;

  int     n_cmp = 0;
  int     n_mis = 0;
  longint cyc = 0;
  bit     mon_en = 1'b0;
  res_t   exp_done[$];
  longint exp_ovr[$];
  res_t   last = '{0, 0, 0, 0, 0, 0, 0};
  longint next_free = 0;
  longint bp_lo = 1, bp_hi = 0, bc_lo = 1, bc_hi = 0;

  int fdr[NPIX], fdg[NPIX], fdb[NPIX], fcr[NPIX], fcg[NPIX], fcb[NPIX];
  bit fv[NPIX];

  always @(posedge clk_25) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint iabs(input longint a);
    return (a < 0) ? -a : a;
  endfunction

  // Frame statistics straight from the definitions: averages over the valid pixels only.
  function automatic res_t model_frame();
    res_t r;
    longint sr = 0, sg = 0, sb = 0, s2 = 0, s4 = 0, cnt = 0;
    longint m2, m4, v, s, t;
    for (int i = 0; i < NPIX; i++) begin
      if (fv[i]) begin
        longint ar, ag, ab, fd2;
        ar = iabs(longint'(fdr[i] * (1 << (DW-R_W))) - longint'(fcr[i] * (1 << (DW-R_W))));
        ag = iabs(longint'(fdg[i] * (1 << (DW-G_W))) - longint'(fcg[i] * (1 << (DW-G_W))));
        ab = iabs(longint'(fdb[i] * (1 << (DW-B_W))) - longint'(fcb[i] * (1 << (DW-B_W))));
        fd2 = ar*ar + ag*ag + ab*ab;
        sr += ar; sg += ag; sb += ab; s2 += fd2; s4 += fd2*fd2; cnt++;
      end
    end
    r.cyc = 0;
    if (cnt == 0) begin
      r.amb_r = 0; r.amb_g = 0; r.amb_b = 0; r.mean = 0; r.vr = 0; r.thr = 0;
    end else begin
      r.amb_r = (sr / cnt) * (1 << (8-DW));
      r.amb_g = (sg / cnt) * (1 << (8-DW));
      r.amb_b = (sb / cnt) * (1 << (8-DW));
      m2 = s2 / cnt;
      m4 = s4 / cnt;
      v  = m4 - m2*m2;
      if (v < 0) v = 0;
      s = 0;
      while ((s+1)*(s+1) <= v) s++;
      t = m2 + THR_K*s;
      r.mean = m2;
      r.vr   = v;
      r.thr  = (t > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : t;
    end
    return r;
  endfunction

  task automatic send_frame(input int gap);
    for (int i = 0; i < NPIX; i++) begin
      @(negedge clk_25);
      valid_i = fv[i];
      syncX_i = 10'(i % H);
      syncY_i = 10'(i / H);
      DVI_R_i = R_W'(fdr[i]); DVI_G_i = G_W'(fdg[i]); DVI_B_i = B_W'(fdb[i]);
      CCD_R_i = R_W'(fcr[i]); CCD_G_i = G_W'(fcg[i]); CCD_B_i = B_W'(fcb[i]);
      if (i == NPIX-1) begin
        longint n;
        res_t r;
        n = cyc + 1;
        if (n + 2 >= next_free) begin
          r = model_frame();
          r.cyc = n + 2 + LAT;
          exp_done.push_back(r);
          bp_lo = bc_lo; bp_hi = bc_hi;
          bc_lo = n + 3; bc_hi = n + 2 + LAT;
          next_free = n + 3 + LAT;
        end else begin
          exp_ovr.push_back(n + 2);
        end
      end
    end
    for (int g = 0; g < gap; g++) begin
      @(negedge clk_25);
      valid_i = 1'b0;
      syncX_i = 10'($urandom); syncY_i = 10'($urandom);
      DVI_R_i = R_W'($urandom); DVI_G_i = G_W'($urandom); DVI_B_i = B_W'($urandom);
      CCD_R_i = R_W'($urandom); CCD_G_i = G_W'($urandom); CCD_B_i = B_W'($urandom);
    end
  endtask

  task automatic fill_random(input bit equal, input bit gaps);
    for (int i = 0; i < NPIX; i++) begin
      fdr[i] = $urandom_range(0, 31); fdg[i] = $urandom_range(0, 63); fdb[i] = $urandom_range(0, 31);
      fcr[i] = equal ? fdr[i] : $urandom_range(0, 31);
      fcg[i] = equal ? fdg[i] : $urandom_range(0, 63);
      fcb[i] = equal ? fdb[i] : $urandom_range(0, 31);
      fv[i]  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    fv[NPIX-1] = 1'b1;
  endtask

  task automatic check_hold(input string tag);
    chk({tag, "_amb_r"}, AMB_SHIFT_R_o, last.amb_r);
    chk({tag, "_amb_g"}, AMB_SHIFT_G_o, last.amb_g);
    chk({tag, "_amb_b"}, AMB_SHIFT_B_o, last.amb_b);
    chk({tag, "_mean"}, mean_fd2_o, last.mean);
    chk({tag, "_var"}, var_fd2_o, last.vr);
    chk({tag, "_thr"}, threshold_o, last.thr);
  endtask

  // Cycle-by-cycle monitor: busy window, done pulses with results, overrun pulses.
  always @(negedge clk_25) begin
    if (mon_en) begin
      res_t r;
      chk("busy", busy_o, ((cyc >= bp_lo && cyc <= bp_hi) || (cyc >= bc_lo && cyc <= bc_hi)));
      if (done_o) begin
        if (exp_done.size() == 0) begin
          chk("done_unexpected", done_o, 1'b0);
        end else begin
          r = exp_done.pop_front();
          chk("done_cycle", cyc, r.cyc);
          last = r;
          check_hold("done");
        end
      end
      if (overrun_o) begin
        if (exp_ovr.size() == 0) chk("overrun_unexpected", overrun_o, 1'b0);
        else chk("overrun_cycle", cyc, exp_ovr.pop_front());
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk_25);
    check_hold("reset");
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_done", done_o, 1'b0);
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk_25);

    // All pixels equal: everything zero.
    fill_random(1'b1, 1'b0);
    send_frame(300);
    check_hold("equal");

    // Constant red difference 10 vs 4 (normalised 20 vs 8).
    fill_random(1'b1, 1'b0);
    for (int i = 0; i < NPIX; i++) begin fdr[i] = 10; fcr[i] = 4; end
    send_frame(300);
    check_hold("red");

    // Half the pixels with green delta 4.
    fill_random(1'b1, 1'b0);
    for (int i = NPIX/2; i < NPIX; i++) begin fdg[i] = $urandom_range(4, 63); fcg[i] = fdg[i] - 4; end
    send_frame(300);
    check_hold("green");

    // Same red pattern with three invalid pixels carrying junk.
    fill_random(1'b1, 1'b0);
    for (int i = 0; i < NPIX; i++) begin fdr[i] = 10; fcr[i] = 4; end
    fv[1] = 1'b0; fv[3] = 1'b0; fv[5] = 1'b0;
    fdr[3] = 31; fcg[3] = 0; fdb[5] = 31;
    send_frame(300);
    check_hold("gaps");

    for (int k = 0; k < 6; k++) begin
      fill_random(1'b0, 1'b1);
      send_frame(300);
      check_hold("rand");
    end

    // Back-to-back frames: overruns while busy, including one landing on the output cycle.
    for (int k = 0; k < 36; k++) begin
      fill_random(1'b0, 1'b0);
      send_frame((k == 35) ? 300 : 0);
    end
    check_hold("b2b");

    // Reset in the middle of the division phase.
    fill_random(1'b0, 1'b0);
    send_frame(100);
    @(posedge clk_25);
    #5;
    reset = 1'b1;
    exp_done.delete();
    bp_lo = 1; bp_hi = 0; bc_lo = 1; bc_hi = 0;
    next_free = 0;
    last = '{0, 0, 0, 0, 0, 0, 0};
    #1;
    check_hold("midrst");
    chk("midrst_busy", busy_o, 1'b0);
    repeat (2) @(negedge clk_25);
    reset = 1'b0;
    repeat (300) @(negedge clk_25);
    check_hold("postrst_idle");

    fill_random(1'b1, 1'b0);
    for (int i = 0; i < NPIX; i++) begin fdr[i] = 10; fcr[i] = 4; end
    send_frame(300);
    check_hold("postrst");

    chk("pending_done", exp_done.size(), 0);
    chk("pending_overrun", exp_ovr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
